regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters: ALU and LOAD.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wb_rr_arbiter.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester IDs for the register-file writeback arbiter
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 2 ** REG_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - 2-way writeback grant; REGFILE_WB_ARB_RR_EN selects round-robin, else LOAD > ALU
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic ld_valid,
    output logic alu_gnt,
    output logic ld_gnt
);

`ifdef REGFILE_WB_ARB_RR_EN
    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        last_d  = last_q;
        if (alu_valid && ld_valid) begin
            // The requester that did not win last time takes the tie.
            if (last_q == REQ_ALU) begin
                ld_gnt = 1'b1;
            end else begin
                alu_gnt = 1'b1;
            end
        end else begin
            alu_gnt = alu_valid;
            ld_gnt  = ld_valid;
        end
        if (ld_gnt) begin
            last_d = REQ_LD;
        end else if (alu_gnt) begin
            last_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_ALU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk & rst;
    assign ld_gnt         = ld_valid;
    assign alu_gnt        = alu_valid && !ld_valid;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with RAW scoreboard (REGFILE_WB_ARB_RR_EN: round-robin ties)
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_W-1:0]    ld_reg,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [REG_W-1:0]    iss_dst,
    input  logic [REG_W-1:0]    chk_reg1,
    input  logic [REG_W-1:0]    chk_reg2,
    output logic                chk_busy1,
    output logic                chk_busy2,
    output logic [REG_W-1:0]    DstReg,
    output logic                WriteReg,
    output logic [DATA_W-1:0]   DstData,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                wb_orphan
);

    logic                alu_gnt;
    logic                ld_gnt;
    logic                write_reg_q, write_reg_d;
    logic [REG_W-1:0]    dst_reg_q, dst_reg_d;
    logic [DATA_W-1:0]   dst_data_q, dst_data_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                orphan_q, orphan_d;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .ld_valid  (ld_valid),
        .alu_gnt   (alu_gnt),
        .ld_gnt    (ld_gnt)
    );

    assign alu_ready = alu_gnt;
    assign ld_ready  = ld_gnt;

    // A register being written this cycle is already readable through the regfile bypass.
    assign iss_ready = !pend_q[iss_dst] || (write_reg_q && dst_reg_q == iss_dst);
    assign chk_busy1 = pend_q[chk_reg1] && !(write_reg_q && dst_reg_q == chk_reg1);
    assign chk_busy2 = pend_q[chk_reg2] && !(write_reg_q && dst_reg_q == chk_reg2);

    always_comb begin
        write_reg_d = alu_gnt || ld_gnt;
        dst_reg_d   = dst_reg_q;
        dst_data_d  = dst_data_q;
        if (ld_gnt) begin
            dst_reg_d  = ld_reg;
            dst_data_d = ld_data;
        end else if (alu_gnt) begin
            dst_reg_d  = alu_reg;
            dst_data_d = alu_data;
        end
    end

    always_comb begin
        pend_d   = pend_q;
        orphan_d = orphan_q;
        if (write_reg_q) begin
            pend_d[dst_reg_q] = 1'b0;
            if (!pend_q[dst_reg_q]) begin
                orphan_d = 1'b1;
            end
        end
        // Applied after the clear so a same-register issue keeps the bit set.
        if (iss_valid && iss_ready) begin
            pend_d[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_reg_q <= 1'b0;
            dst_reg_q   <= '0;
            dst_data_q  <= '0;
            pend_q      <= '0;
            orphan_q    <= 1'b0;
        end else begin
            write_reg_q <= write_reg_d;
            dst_reg_q   <= dst_reg_d;
            dst_data_q  <= dst_data_d;
            pend_q      <= pend_d;
            orphan_q    <= orphan_d;
        end
    end

    assign WriteReg  = write_reg_q;
    assign DstReg    = dst_reg_q;
    assign DstData   = dst_data_q;
    assign pend_mask = pend_q;
    assign wb_orphan = orphan_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, iss_valid;
    logic [3:0]  alu_reg, ld_reg, iss_dst, chk_reg1, chk_reg2;
    logic [15:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, iss_ready, chk_busy1, chk_busy2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] pend_mask;
    logic        wb_orphan;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        av; logic [3:0] ar; logic [15:0] ad;
        logic        lv; logic [3:0] lr; logic [15:0] ldat;
        logic        iv; logic [3:0] id;
        logic [3:0]  c1; logic [3:0] c2;
        logic        ea, el, ei, eb1, eb2;
        logic        ewr; logic [3:0] edst; logic [15:0] edat;
        logic [15:0] epend; logic eorph;
    } vec_t;

    vec_t vecs[11];

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dst(iss_dst),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .pend_mask(pend_mask), .wb_orphan(wb_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = 4'd0; alu_data = 16'h0;
        ld_valid  = 1'b0; ld_reg  = 4'd0; ld_data  = 16'h0;
        iss_valid = 1'b0; iss_dst = 4'd0;
        chk_reg1  = 4'd0; chk_reg2 = 4'd0;
    endtask

    initial begin
        logic exp_ld [4];
        logic exp_alu[4];

        vecs[0]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd5, 4'd5,4'd3, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd0,16'h0000,16'h0020,1'b0};
        vecs[1]  = '{1'b1,4'd5,16'hBEEF, 1'b0,4'd0,16'h0000, 1'b0,4'd5, 4'd5,4'd3, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,4'd5,16'hBEEF,16'h0020,1'b0};
        vecs[2]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd5, 4'd5,4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd5,16'hBEEF,16'h0000,1'b0};
        vecs[3]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd3, 4'd3,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd5,16'hBEEF,16'h0008,1'b0};
        vecs[4]  = '{1'b1,4'd3,16'h1234, 1'b0,4'd0,16'h0000, 1'b1,4'd3, 4'd3,4'd3, 1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,4'd3,16'h1234,16'h0008,1'b0};
        vecs[5]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd3, 4'd3,4'd3, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd3,16'h1234,16'h0008,1'b0};
        vecs[6]  = '{1'b1,4'd3,16'h5678, 1'b0,4'd0,16'h0000, 1'b0,4'd3, 4'd3,4'd3, 1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,4'd3,16'h5678,16'h0008,1'b0};
        vecs[7]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd3, 4'd3,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd3,16'h5678,16'h0000,1'b0};
        vecs[8]  = '{1'b0,4'd0,16'h0000, 1'b1,4'd9,16'hA5A5, 1'b0,4'd9, 4'd9,4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,4'd9,16'hA5A5,16'h0000,1'b0};
        vecs[9]  = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd9, 4'd9,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd9,16'hA5A5,16'h0000,1'b1};
        vecs[10] = '{1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd9, 4'd9,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,4'd9,16'hA5A5,16'h0000,1'b1};

`ifdef REGFILE_WB_ARB_RR_EN
        exp_ld  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_alu = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ld  = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_alu = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        idle_inputs();
        rst = 1'b0;
        #2;
        check("rst_writereg", WriteReg, 1'b0);
        check("rst_dstreg", DstReg, 4'd0);
        check("rst_dstdata", DstData, 16'h0);
        check("rst_pend", pend_mask, 16'h0);
        check("rst_orphan", wb_orphan, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            ld_valid  = vecs[i].lv; ld_reg  = vecs[i].lr; ld_data  = vecs[i].ldat;
            iss_valid = vecs[i].iv; iss_dst = vecs[i].id;
            chk_reg1  = vecs[i].c1; chk_reg2 = vecs[i].c2;
            #1;
            check($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].ea);
            check($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].el);
            check($sformatf("v%0d_iss_ready", i), iss_ready, vecs[i].ei);
            check($sformatf("v%0d_chk_busy1", i), chk_busy1, vecs[i].eb1);
            check($sformatf("v%0d_chk_busy2", i), chk_busy2, vecs[i].eb2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_writereg", i), WriteReg, vecs[i].ewr);
            check($sformatf("v%0d_dstreg", i), DstReg, vecs[i].edst);
            check($sformatf("v%0d_dstdata", i), DstData, vecs[i].edat);
            check($sformatf("v%0d_pend", i), pend_mask, vecs[i].epend);
            check($sformatf("v%0d_orphan", i), wb_orphan, vecs[i].eorph);
        end

        // Reset landing in a grant cycle: the accepted write must never appear.
        @(negedge clk);
        idle_inputs();
        iss_valid = 1'b1; iss_dst = 4'd7;
        @(posedge clk);
        #1;
        check("r6_pend_set", pend_mask, 16'h0080);
        @(negedge clk);
        iss_valid = 1'b0;
        ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'h7777;
        #1;
        check("r6_ld_ready", ld_ready, 1'b1);
        rst = 1'b0;
        #1;
        check("r6_async_writereg", WriteReg, 1'b0);
        check("r6_async_pend", pend_mask, 16'h0);
        check("r6_async_orphan", wb_orphan, 1'b0);
        @(posedge clk);
        #1;
        check("r6_no_pulse", WriteReg, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("r6_post_release_writereg", WriteReg, 1'b0);
        check("r6_post_release_dstreg", DstReg, 4'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h00A1;
            ld_valid  = 1'b1; ld_reg  = 4'd2; ld_data  = 16'h00D2;
            #1;
            check($sformatf("tie%0d_ld_ready", i), ld_ready, exp_ld[i]);
            check($sformatf("tie%0d_alu_ready", i), alu_ready, exp_alu[i]);
            @(posedge clk);
            #1;
            check($sformatf("tie%0d_writereg", i), WriteReg, 1'b1);
            check($sformatf("tie%0d_dstreg", i), DstReg, exp_ld[i] ? 4'd2 : 4'd1);
            check($sformatf("tie%0d_dstdata", i), DstData, exp_ld[i] ? 16'h00D2 : 16'h00A1);
        end

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("tail_writereg", WriteReg, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
